// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: reads opcode plus 0-2 operand bytes at PC and
// presents one instruction record to the decode stage over valid/ready.
module inst_fetch_unit #(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'hFFFC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_req,
    input  logic              mem_rd_ack,
    input  logic [7:0]        mem_rd_data,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [7:0]        inst_opcode,
    output logic [15:0]       inst_operand,
    output logic [1:0]        inst_len,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] pc_out
);

    typedef enum logic [1:0] {FETCH_OP, FETCH_LO, FETCH_HI, HOLD} state_t;

    state_t              state;
    state_t              state_next;
    logic                req_next;
    logic                ack_take;
    logic [ADDR_W-1:0]   pc_inc;

    // Instruction length decoded from the raw opcode byte.
    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = op[7:4];
        lo = op[3:0];
        if (lo == 4'h8 || lo == 4'hA || op == 8'h00 || op == 8'h40 || op == 8'h60)
            op_len = 2'd1;
        else if (lo >= 4'hC || op == 8'h20 || ((lo == 4'h9 || lo == 4'hB) && hi[0]))
            op_len = 2'd3;
        else
            op_len = 2'd2;
    endfunction

    // An ack only counts while a request is outstanding.
    assign ack_take   = mem_rd_req & mem_rd_ack;
    assign pc_inc     = pc_out + ADDR_W'(1);
    assign mem_addr   = pc_out;
    assign inst_valid = (state == HOLD);

    always_comb begin
        state_next = state;
        case (state)
            FETCH_OP: if (ack_take) state_next = (op_len(mem_rd_data) == 2'd1) ? HOLD : FETCH_LO;
            FETCH_LO: if (ack_take) state_next = (inst_len == 2'd2) ? HOLD : FETCH_HI;
            FETCH_HI: if (ack_take) state_next = HOLD;
            HOLD:     if (inst_ready) state_next = FETCH_OP;
            default:  state_next = FETCH_OP;
        endcase
        if (pc_load)
            state_next = FETCH_OP;
        // Request drops for one cycle after each ack and on a redirect.
        req_next = (state_next != HOLD) && !ack_take && !pc_load;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= FETCH_OP;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_out       <= RESET_PC;
            mem_rd_req   <= 1'b0;
            inst_opcode  <= 8'h00;
            inst_operand <= 16'h0000;
            inst_len     <= 2'd1;
            inst_pc      <= RESET_PC;
        end else begin
            mem_rd_req <= req_next;
            if (pc_load) begin
                pc_out <= pc_load_val;
            end else if (ack_take) begin
                pc_out <= pc_inc;
                case (state)
                    FETCH_OP: begin
                        inst_opcode  <= mem_rd_data;
                        inst_pc      <= pc_out;
                        inst_len     <= op_len(mem_rd_data);
                        inst_operand <= 16'h0000;
                    end
                    FETCH_LO: inst_operand[7:0]  <= mem_rd_data;
                    FETCH_HI: inst_operand[15:8] <= mem_rd_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a table of instructions plus hand-written
// sequences for reset, wait states, back-pressure, redirects and PC wrap.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic        mem_rd_req;
    logic        mem_rd_ack;
    logic [7:0]  mem_rd_data;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        inst_valid;
    logic        inst_ready;
    logic [7:0]  inst_opcode;
    logic [15:0] inst_operand;
    logic [1:0]  inst_len;
    logic [15:0] inst_pc;
    logic [15:0] pc_out;

    inst_fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFC)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd_req(mem_rd_req),
        .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data), .pc_load(pc_load),
        .pc_load_val(pc_load_val), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_opcode(inst_opcode), .inst_operand(inst_operand), .inst_len(inst_len),
        .inst_pc(inst_pc), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    int  ack_delay = 0;
    int  wait_cnt  = 0;
    bit  manual    = 1'b0;
    logic       man_ack  = 1'b0;
    logic [7:0] man_data = 8'h00;
    bit  mon_en = 1'b0;
    logic        prev_req = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    int  addr_viol = 0;
    int  n_tests = 0;
    int  n_fail  = 0;

    // Memory responder: acks after ack_delay request cycles, or follows manual drive.
    always @(negedge clk) begin
        if (manual) begin
            mem_rd_ack  = man_ack;
            mem_rd_data = man_data;
        end else begin
            mem_rd_ack = 1'b0;
            if (mem_rd_req) begin
                if (wait_cnt >= ack_delay) begin
                    mem_rd_ack  = 1'b1;
                    mem_rd_data = mem[mem_addr];
                    wait_cnt    = 0;
                end else begin
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
        if (mon_en) begin
            if (mem_rd_req && prev_req && mem_addr != prev_addr)
                addr_viol = addr_viol + 1;
            prev_req  = mem_rd_req;
            prev_addr = mem_addr;
        end
    end

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [1:0]  len;
        logic [15:0] operand;
    } vec_t;

    vec_t vecs [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!inst_valid && n < 64) begin
            tick();
            n++;
        end
        chk(name, {31'd0, inst_valid}, 32'd1);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!mem_rd_req && n < 16) begin
            tick();
            n++;
        end
        chk(name, {31'd0, mem_rd_req}, 32'd1);
    endtask

    task automatic redirect(input logic [15:0] target);
        pc_load     = 1'b1;
        pc_load_val = target;
        tick();
        pc_load     = 1'b0;
    endtask

    task automatic handshake(input string name);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk(name, {31'd0, inst_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; pc_load = 1'b0; pc_load_val = 16'h0; inst_ready = 1'b0;
        mem_rd_ack = 1'b0; mem_rd_data = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        vecs[0]  = '{16'h1000, 8'hA9, 8'h42, 8'h99, 2'd2, 16'h0042};
        vecs[1]  = '{16'h1010, 8'h8D, 8'h00, 8'h03, 2'd3, 16'h0300};
        vecs[2]  = '{16'h1020, 8'hEA, 8'hFF, 8'hFF, 2'd1, 16'h0000};
        vecs[3]  = '{16'h1030, 8'h00, 8'h11, 8'h22, 2'd1, 16'h0000};
        vecs[4]  = '{16'h1040, 8'h40, 8'h33, 8'h44, 2'd1, 16'h0000};
        vecs[5]  = '{16'h1050, 8'h60, 8'h55, 8'h66, 2'd1, 16'h0000};
        vecs[6]  = '{16'h1060, 8'h20, 8'h34, 8'h12, 2'd3, 16'h1234};
        vecs[7]  = '{16'h1070, 8'h19, 8'hCD, 8'hAB, 2'd3, 16'hABCD};
        vecs[8]  = '{16'h1080, 8'h09, 8'h77, 8'h88, 2'd2, 16'h0077};
        vecs[9]  = '{16'h1090, 8'hBB, 8'h01, 8'h02, 2'd3, 16'h0201};
        vecs[10] = '{16'h10A0, 8'h4A, 8'h5A, 8'h5B, 2'd1, 16'h0000};
        vecs[11] = '{16'h10B0, 8'h10, 8'hFE, 8'h99, 2'd2, 16'h00FE};
        vecs[12] = '{16'h10C0, 8'hFF, 8'h11, 8'h22, 2'd3, 16'h2211};
        vecs[13] = '{16'h10D0, 8'hB9, 8'h5A, 8'hA5, 2'd3, 16'hA55A};
        vecs[14] = '{16'h10E0, 8'h88, 8'h01, 8'h01, 2'd1, 16'h0000};

        // Reset state
        mem[16'hFFFC] = 8'hA9;
        mem[16'hFFFD] = 8'h42;
        tick(); tick();
        chk("rst_pc_out",   {16'd0, pc_out}, 32'hFFFC);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'hFFFC);
        chk("rst_req",      {31'd0, mem_rd_req}, 32'd0);
        chk("rst_valid",    {31'd0, inst_valid}, 32'd0);
        chk("rst_opcode",   {24'd0, inst_opcode}, 32'd0);
        chk("rst_operand",  {16'd0, inst_operand}, 32'd0);
        chk("rst_len",      {30'd0, inst_len}, 32'd1);
        chk("rst_inst_pc",  {16'd0, inst_pc}, 32'hFFFC);
        rst = 1'b1;

        // First fetch from the reset PC
        wait_valid("boot_valid");
        chk("boot_opcode",  {24'd0, inst_opcode}, 32'hA9);
        chk("boot_operand", {16'd0, inst_operand}, 32'h0042);
        chk("boot_len",     {30'd0, inst_len}, 32'd2);
        chk("boot_inst_pc", {16'd0, inst_pc}, 32'hFFFC);
        chk("boot_pc_out",  {16'd0, pc_out}, 32'hFFFE);
        handshake("boot_release");

        // Table of instructions covering the length rule
        for (int v = 0; v < 15; v++) begin
            mem[vecs[v].pc]          = vecs[v].b0;
            mem[vecs[v].pc + 16'd1]  = vecs[v].b1;
            mem[vecs[v].pc + 16'd2]  = vecs[v].b2;
            redirect(vecs[v].pc);
            wait_valid($sformatf("v%0d_valid", v));
            chk($sformatf("v%0d_opcode", v),  {24'd0, inst_opcode}, {24'd0, vecs[v].b0});
            chk($sformatf("v%0d_len", v),     {30'd0, inst_len}, {30'd0, vecs[v].len});
            chk($sformatf("v%0d_operand", v), {16'd0, inst_operand}, {16'd0, vecs[v].operand});
            chk($sformatf("v%0d_inst_pc", v), {16'd0, inst_pc}, {16'd0, vecs[v].pc});
            chk($sformatf("v%0d_pc_out", v),  {16'd0, pc_out}, {16'd0, vecs[v].pc + 16'(vecs[v].len)});
            handshake($sformatf("v%0d_release", v));
        end

        // Slow memory: three wait cycles per byte, address must hold
        mem[16'h0200] = 8'h8D; mem[16'h0201] = 8'h00; mem[16'h0202] = 8'h03;
        ack_delay = 3;
        redirect(16'h0200);
        mon_en = 1'b1;
        wait_valid("slow_valid");
        mon_en = 1'b0;
        ack_delay = 0;
        chk("slow_opcode",  {24'd0, inst_opcode}, 32'h8D);
        chk("slow_operand", {16'd0, inst_operand}, 32'h0300);
        chk("slow_len",     {30'd0, inst_len}, 32'd3);
        chk("slow_pc_out",  {16'd0, pc_out}, 32'h0203);
        chk("slow_addr_stable", addr_viol, 32'd0);
        handshake("slow_release");

        // Back-pressure on a one-byte record
        mem[16'h0300] = 8'hEA;
        redirect(16'h0300);
        wait_valid("bp_valid");
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp%0d_valid", c),  {31'd0, inst_valid}, 32'd1);
            chk($sformatf("bp%0d_opcode", c), {24'd0, inst_opcode}, 32'hEA);
            chk($sformatf("bp%0d_req", c),    {31'd0, mem_rd_req}, 32'd0);
        end
        chk("bp_len",    {30'd0, inst_len}, 32'd1);
        chk("bp_pc_out", {16'd0, pc_out}, 32'h0301);
        handshake("bp_release");

        // Redirect during FETCH_LO with a simultaneous ack
        manual = 1'b1;
        man_ack = 1'b0;
        redirect(16'h0400);
        wait_req("rd_req_op");
        man_ack = 1'b1; man_data = 8'hA9;
        tick();
        man_ack = 1'b0;
        chk("rd_pc_after_op", {16'd0, pc_out}, 32'h0401);
        wait_req("rd_req_lo");
        man_ack = 1'b1; man_data = 8'h55;
        pc_load = 1'b1; pc_load_val = 16'hC000;
        tick();
        pc_load = 1'b0; man_ack = 1'b0;
        chk("rd_valid",    {31'd0, inst_valid}, 32'd0);
        chk("rd_req",      {31'd0, mem_rd_req}, 32'd0);
        chk("rd_pc_out",   {16'd0, pc_out}, 32'hC000);
        chk("rd_mem_addr", {16'd0, mem_addr}, 32'hC000);
        mem[16'hC000] = 8'hEA;
        manual = 1'b0;
        wait_valid("rd_new_valid");
        chk("rd_new_opcode",  {24'd0, inst_opcode}, 32'hEA);
        chk("rd_new_inst_pc", {16'd0, inst_pc}, 32'hC000);
        chk("rd_new_operand", {16'd0, inst_operand}, 32'h0000);
        handshake("rd_release");

        // Operand fetch straddling the address wrap
        mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
        redirect(16'hFFFE);
        wait_valid("wrap_valid");
        chk("wrap_operand", {16'd0, inst_operand}, 32'h1234);
        chk("wrap_len",     {30'd0, inst_len}, 32'd3);
        chk("wrap_inst_pc", {16'd0, inst_pc}, 32'hFFFE);
        chk("wrap_pc_out",  {16'd0, pc_out}, 32'h0001);
        handshake("wrap_release");

        // Reset while a record is pending
        mem[16'h0500] = 8'hEA;
        redirect(16'h0500);
        wait_valid("rv_valid");
        rst = 1'b0;
        tick();
        chk("rv_valid_cleared", {31'd0, inst_valid}, 32'd0);
        chk("rv_pc_out",        {16'd0, pc_out}, 32'hFFFC);
        chk("rv_req",           {31'd0, mem_rd_req}, 32'd0);
        chk("rv_opcode",        {24'd0, inst_opcode}, 32'd0);
        rst = 1'b1;
        tick();
        wait_req("rv_restart_req");
        chk("rv_restart_addr", {16'd0, mem_addr}, 32'hFFFC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
